// File: rtl/conv_relu_pool_unit.sv
// conv_relu_pool_unit
//   Streaming conv layer slice: KSIZE x KSIZE signed fixed-point convolution,
//   bias add, saturate, ReLU, then POOL x POOL max-pool. One KSIZE-pixel column
//   is accepted per beat; the caller supplies already-sliding rows, so every
//   input row yields one conv row.
//   Pipeline: accept -> stage1 (products) -> stage2 (sum/bias/shift/sat/ReLU)
//   -> pool/output register. The whole pipe freezes while the output is stalled.
//   Optional macro CONV_ROUND_EN: round half up before the >>FRAC_W instead of
//   truncating.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   weight_we/addr/data       runtime weight write (row-major, 0 = top-left)
//   bias_we/bias_data         runtime bias write (same Q format as weights)
//   frame_start               marks the accepted beat as column 0 / row 0
//   in_valid/in_ready/in_col  input column stream, [DATA_W-1:0] = top pixel
//   out_valid/out_ready/out_pix  pooled, non-negative result stream
module conv_relu_pool_unit #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int KSIZE   = 3,
  parameter int ROW_LEN = 28,
  parameter int POOL    = 2,
  parameter int ACC_W   = 40,
  localparam int NTAP   = KSIZE * KSIZE,
  localparam int WA_W   = (NTAP > 1) ? $clog2(NTAP) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    weight_we,
  input  logic [WA_W-1:0]         weight_addr,
  input  logic [DATA_W-1:0]       weight_data,
  input  logic                    bias_we,
  input  logic [DATA_W-1:0]       bias_data,
  input  logic                    frame_start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [KSIZE*DATA_W-1:0] in_col,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_pix
);
  localparam int NSLOT  = (ROW_LEN - KSIZE + 1) / POOL;
  localparam int COL_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int SLOT_W = $clog2(NSLOT + 1);
  localparam int PW     = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ROW_LEN - 1);
  localparam logic [COL_W-1:0]  COL_CONV0 = COL_W'(KSIZE - 1);
  localparam logic [PW-1:0]     POOL_LAST = PW'(POOL - 1);
  // Slot value NSLOT marks conv columns past the last full pool window.
  localparam logic [SLOT_W-1:0] SLOT_END  = SLOT_W'(NSLOT);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
`ifdef CONV_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'sd1 <<< (FRAC_W - 1));
`else
  localparam logic signed [ACC_W-1:0] RND = {ACC_W{1'b0}};
`endif

  // Pool bookkeeping that travels alongside each conv result.
  typedef struct packed {
    logic              first_h;
    logic              last_h;
    logic              keep;
    logic              first_v;
    logic              last_v;
    logic [SLOT_W-1:0] slot;
  } tag_t;

  logic signed [DATA_W-1:0] weight_q [NTAP];
  logic signed [DATA_W-1:0] weight_d [NTAP];
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic [KSIZE*DATA_W-1:0]  win_q [KSIZE];
  logic [KSIZE*DATA_W-1:0]  win_d [KSIZE];
  logic [COL_W-1:0]         col_q, col_d, col_cur;
  logic [PW-1:0]            hpos_q, hpos_d, hpos_cur, vpos_q, vpos_d, vpos_cur;
  logic [SLOT_W-1:0]        slot_q, slot_d, slot_cur;
  logic signed [PROD_W-1:0] prod_q [NTAP];
  logic signed [PROD_W-1:0] prod_d [NTAP];
  logic                     s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  tag_t                     s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [DATA_W-1:0]        s2_pix_q, s2_pix_d;
  logic [DATA_W-1:0]        hmax_q, hmax_d;
  logic [DATA_W-1:0]        lb_q [NSLOT];
  logic [DATA_W-1:0]        lb_d [NSLOT];
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_pix_q, out_pix_d;
  logic                     stall, accept, conv_hit;
  logic signed [ACC_W-1:0]  acc, shifted, bias_ext;
  logic signed [DATA_W-1:0] pix_s;
  logic [DATA_W-1:0]        h_val, v_val;
  logic [SLOT_W-1:0]        slot_idx;

  // Input side: coefficient writes, column window, counters and stage1 products.
  always_comb begin
    stall    = out_valid_q & ~out_ready;
    accept   = in_valid & ~stall;
    col_cur  = frame_start ? {COL_W{1'b0}}  : col_q;
    hpos_cur = frame_start ? {PW{1'b0}}     : hpos_q;
    vpos_cur = frame_start ? {PW{1'b0}}     : vpos_q;
    slot_cur = frame_start ? {SLOT_W{1'b0}} : slot_q;
    conv_hit = (col_cur >= COL_CONV0);

    weight_d = weight_q;
    bias_d   = bias_q;
    if (weight_we && ({1'b0, weight_addr} < (WA_W + 1)'(NTAP))) begin
      weight_d[weight_addr] = weight_data;
    end else begin
      weight_d = weight_q;
    end
    if (bias_we) begin
      bias_d = bias_data;
    end else begin
      bias_d = bias_q;
    end

    win_d  = win_q;
    col_d  = col_q;
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    slot_d = slot_q;
    if (accept) begin
      // frame_start flushes older columns so a new frame never mixes with the last.
      for (int i = 0; i < KSIZE - 1; i++) begin
        win_d[i] = frame_start ? {(KSIZE*DATA_W){1'b0}} : win_q[i+1];
      end
      win_d[KSIZE-1] = in_col;
      if (col_cur == COL_LAST) begin
        col_d  = {COL_W{1'b0}};
        hpos_d = {PW{1'b0}};
        slot_d = {SLOT_W{1'b0}};
        vpos_d = (vpos_cur == POOL_LAST) ? {PW{1'b0}} : vpos_cur + 1'b1;
      end else begin
        col_d  = col_cur + 1'b1;
        vpos_d = vpos_cur;
        hpos_d = hpos_cur;
        slot_d = slot_cur;
        if (conv_hit) begin
          if (hpos_cur == POOL_LAST) begin
            hpos_d = {PW{1'b0}};
            slot_d = (slot_cur == SLOT_END) ? SLOT_END : slot_cur + 1'b1;
          end else begin
            hpos_d = hpos_cur + 1'b1;
          end
        end else begin
          hpos_d = hpos_cur;
        end
      end
    end else begin
      win_d = win_q;
    end

    s1_tag_d.first_h = (hpos_cur == {PW{1'b0}});
    s1_tag_d.last_h  = (hpos_cur == POOL_LAST);
    s1_tag_d.keep    = (slot_cur != SLOT_END);
    s1_tag_d.first_v = (vpos_cur == {PW{1'b0}});
    s1_tag_d.last_v  = (vpos_cur == POOL_LAST);
    s1_tag_d.slot    = slot_cur;
    pix_s            = {DATA_W{1'b0}};
    prod_d           = prod_q;
    s1_valid_d       = s1_valid_q;
    if (!stall) begin
      s1_valid_d = accept & conv_hit;
      // Window column 0 is the oldest, so weight (r, c) pairs with win_d[c] row r.
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          pix_s = win_d[c][r*DATA_W +: DATA_W];
          prod_d[r*KSIZE+c] = PROD_W'(pix_s) * PROD_W'(weight_q[r*KSIZE+c]);
        end
      end
    end else begin
      s1_tag_d = s1_tag_q;
    end
  end

  // Stage2 math: accumulate, add bias, rescale, saturate and ReLU.
  always_comb begin
    acc = {ACC_W{1'b0}};
    for (int i = 0; i < NTAP; i++) begin
      acc = acc + {{(ACC_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
    end
    bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    acc      = acc + (bias_ext <<< FRAC_W) + RND;
    shifted  = acc >>> FRAC_W;
    if (shifted[ACC_W-1]) begin
      s2_pix_d = {DATA_W{1'b0}};
    end else if (shifted > SAT_MAX) begin
      s2_pix_d = SAT_MAX[DATA_W-1:0];
    end else begin
      s2_pix_d = shifted[DATA_W-1:0];
    end
    if (stall) begin
      s2_pix_d   = s2_pix_q;
      s2_valid_d = s2_valid_q;
      s2_tag_d   = s2_tag_q;
    end else begin
      s2_valid_d = s1_valid_q;
      s2_tag_d   = s1_tag_q;
    end
  end

  // Pool: running horizontal max, line buffer of vertical maxima, output register.
  always_comb begin
    hmax_d      = hmax_q;
    lb_d        = lb_q;
    out_pix_d   = out_pix_q;
    out_valid_d = out_valid_q & ~out_ready;
    slot_idx    = s2_tag_q.keep ? s2_tag_q.slot : {SLOT_W{1'b0}};
    h_val = (s2_tag_q.first_h || (s2_pix_q > hmax_q)) ? s2_pix_q : hmax_q;
    v_val = (s2_tag_q.first_v || (h_val > lb_q[slot_idx])) ? h_val : lb_q[slot_idx];
    if (!stall && s2_valid_q) begin
      hmax_d = h_val;
      if (s2_tag_q.last_h && s2_tag_q.keep) begin
        if (s2_tag_q.last_v) begin
          out_valid_d = 1'b1;
          out_pix_d   = v_val;
        end else begin
          lb_d[slot_idx] = v_val;
        end
      end else begin
        hmax_d = h_val;
      end
    end else begin
      hmax_d = hmax_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) begin
        weight_q[i] <= {DATA_W{1'b0}};
        prod_q[i]   <= {PROD_W{1'b0}};
      end
      for (int i = 0; i < KSIZE; i++) win_q[i] <= {(KSIZE*DATA_W){1'b0}};
      for (int i = 0; i < NSLOT; i++) lb_q[i] <= {DATA_W{1'b0}};
      bias_q      <= {DATA_W{1'b0}};
      col_q       <= {COL_W{1'b0}};
      hpos_q      <= {PW{1'b0}};
      vpos_q      <= {PW{1'b0}};
      slot_q      <= {SLOT_W{1'b0}};
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      s2_pix_q    <= {DATA_W{1'b0}};
      hmax_q      <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      out_pix_q   <= {DATA_W{1'b0}};
    end else begin
      weight_q    <= weight_d;
      prod_q      <= prod_d;
      win_q       <= win_d;
      lb_q        <= lb_d;
      bias_q      <= bias_d;
      col_q       <= col_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      slot_q      <= slot_d;
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      s2_pix_q    <= s2_pix_d;
      hmax_q      <= hmax_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
endmodule

// File: tb/tb_conv_relu_pool_unit.sv
// Scoreboard bench for conv_relu_pool_unit (default parameters).
module tb_conv_relu_pool_unit;
  localparam int DW = 16;
  localparam int K  = 3;
  localparam int RL = 28;
  localparam int NS = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          weight_we;
  logic [3:0]    weight_addr;
  logic [DW-1:0] weight_data;
  logic          bias_we;
  logic [DW-1:0] bias_data;
  logic          frame_start;
  logic          in_valid;
  logic          in_ready;
  logic [K*DW-1:0] in_col;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pix;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  conv_relu_pool_unit dut (
    .clk(clk), .rst(rst),
    .weight_we(weight_we), .weight_addr(weight_addr), .weight_data(weight_data),
    .bias_we(bias_we), .bias_data(bias_data),
    .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix)
  );

  // Monitor: compares each presented output with the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid: got %0b want 0", out_valid);
      end
    end else if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0d with nothing expected", out_pix);
      end else begin
        if (out_pix !== DW'(exp_q[0])) begin
          errors++;
          $display("FAIL out_pix: got %0d want %0d", out_pix, exp_q[0]);
        end
        if (!out_ready) begin
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %0b want 0", in_ready);
          end
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input int mode, input int cval, input int r, input int c);
    case (mode)
      0:       return DW'(cval);
      1:       return DW'(c + 100 * r);
      default: return DW'(200 - c - 50 * r);
    endcase
  endfunction

  // Closed-form pooled result for pool row m, slot k (weights all 1.0, bias 0).
  function automatic int expv(input int mode, input int cval, input int m, input int k);
    case (mode)
      0:       return cval;
      1:       return 18 * k + 18 + 900 * (2 * m + 1);
      default: return 1791 - 18 * k - 900 * m;
    endcase
  endfunction

  task automatic send_beat(input logic [K*DW-1:0] col, input logic fs);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_col = col;
    frame_start = fs;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: in_ready stayed 0 for %0d cycles, want 1", n);
    end
    in_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  // Sends up to max_beats columns of an nrows frame; pushes 13 values per pooled row.
  task automatic send_frame(input int mode, input int cval, input int expc,
                            input int nrows, input bit do_push, input int max_beats);
    logic [K*DW-1:0] col;
    int beats;
    beats = 0;
    for (int r = 0; r < nrows; r++) begin
      if (do_push && (r % 2 == 1)) begin
        for (int k = 0; k < NS; k++) exp_q.push_back(mode == 0 ? expc : expv(mode, cval, r / 2, k));
      end
      for (int c = 0; c < RL; c++) begin
        if (beats < max_beats) begin
          for (int p = 0; p < K; p++) col[p*DW +: DW] = pix(mode, cval, r, c);
          send_beat(col, (r == 0) && (c == 0));
          beats++;
        end
      end
    end
  endtask

  task automatic load_weights(input logic [DW-1:0] w_all, input logic [DW-1:0] w_ctr);
    for (int i = 0; i < K * K; i++) begin
      weight_we = 1'b1;
      weight_addr = 4'(i);
      weight_data = (i == 4) ? w_ctr : w_all;
      tick();
    end
    weight_we = 1'b0;
  endtask

  task automatic set_bias(input logic [DW-1:0] v);
    bias_we = 1'b1;
    bias_data = v;
    tick();
    bias_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d outputs missing, want 0", exp_q.size());
    end
    repeat (6) tick();
  endtask

  initial begin
    rst = 1'b1;
    weight_we = 1'b0; weight_addr = 4'd0; weight_data = 16'd0;
    bias_we = 1'b0; bias_data = 16'd0;
    frame_start = 1'b0; in_valid = 1'b0; in_col = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    load_weights(16'h0100, 16'h0100);
    send_frame(0, 10, 90, 2, 1'b1, 9999);          // 9 * 10
    send_frame(0, -5, 0, 2, 1'b1, 9999);           // negative -> ReLU 0
    send_frame(0, 32'h7FFF, 32'h7FFF, 2, 1'b1, 9999); // saturation
    set_bias(16'd10);
    send_frame(0, 10, 100, 2, 1'b1, 9999);         // 90 + bias 10
    set_bias(16'd0);

    // Backpressure: 20 stalled cycles in the middle of the second row.
    fork
      begin
        repeat (40) tick();
        out_ready = 1'b0;
        repeat (20) tick();
        out_ready = 1'b1;
      end
    join_none
    send_frame(1, 0, 0, 4, 1'b1, 9999);

    // Third row is a leftover; next frame_start must restart vertical pooling.
    send_frame(2, 0, 0, 3, 1'b1, 9999);
    send_frame(2, 0, 0, 2, 1'b1, 9999);

    // Centre weight 0.5 on pixel value 1: truncates to 0, rounds to 1.
    load_weights(16'h0000, 16'h0080);
`ifdef CONV_ROUND_EN
    send_frame(0, 1, 1, 2, 1'b1, 9999);
`else
    send_frame(0, 1, 0, 2, 1'b1, 9999);
`endif
    drain();

    // Reset with a result in flight; weights return to zero.
    load_weights(16'h0100, 16'h0100);
    send_frame(1, 0, 0, 2, 1'b0, 33);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    send_frame(0, 10, 0, 2, 1'b1, 9999);
    load_weights(16'h0100, 16'h0100);
    send_frame(1, 0, 0, 2, 1'b1, 9999);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
